// File: rtl/pipe_hazard_unit_pkg.sv
// rtl/pipe_hazard_unit_pkg.sv - shared CPU types for the hazard/forwarding unit
package cpu_pkg;

    localparam int RF_AW = 5;
    localparam logic [RF_AW-1:0] XZR = 5'd31;

    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10
    } fwd_sel_e;

    typedef struct packed {
        logic             valid;
        logic [RF_AW-1:0] rd;
        logic             regwrite;
        logic             memread;
    } haz_entry_t;

    // A producer only matters if it really writes a non-zero register.
    function automatic logic entry_writing(haz_entry_t e, logic [RF_AW-1:0] zero_reg);
        return e.valid && e.regwrite && (e.rd != zero_reg);
    endfunction

endpackage

// File: rtl/pipe_hazard_unit_if.sv
// rtl/pipe_hazard_unit_if.sv - ID-side request and hazard-control response bundle
interface pipe_hazard_unit_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    import cpu_pkg::*;

    logic              id_valid;
    logic [REG_AW-1:0] id_rn;
    logic [REG_AW-1:0] id_rm;
    logic              id_use_rn;
    logic              id_use_rm;
    logic [REG_AW-1:0] id_rd;
    logic              id_regwrite;
    logic              id_memread;
    logic              ex_br_taken;

    logic              stall;
    logic              flush;
    fwd_sel_e          fwd_a;
    fwd_sel_e          fwd_b;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;
    haz_entry_t        ex_ent;
    haz_entry_t        mem_ent;
    haz_entry_t        wb_ent;

    modport master (
        output id_valid, id_rn, id_rm, id_use_rn, id_use_rm, id_rd,
               id_regwrite, id_memread, ex_br_taken,
        input  stall, flush, fwd_a, fwd_b, stall_cnt, flush_cnt,
               ex_ent, mem_ent, wb_ent
    );

    modport slave (
        input  id_valid, id_rn, id_rm, id_use_rn, id_use_rm, id_rd,
               id_regwrite, id_memread, ex_br_taken,
        output stall, flush, fwd_a, fwd_b, stall_cnt, flush_cnt,
               ex_ent, mem_ent, wb_ent
    );

endinterface

// File: rtl/pipe_hazard_unit_track_reg.sv
// rtl/pipe_hazard_unit_track_reg.sv - one in-flight destination tracker entry
module hazard_track_reg
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  haz_entry_t d,
    output haz_entry_t q
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_hazard_unit.sv
// rtl/pipe_hazard_unit.sv - load-use stall, branch flush and EX operand forwarding control
module pipe_hazard_unit
    import cpu_pkg::*;
#(
    parameter int                REG_AW   = RF_AW,
    parameter logic [REG_AW-1:0] ZERO_REG = XZR,
    parameter int                CNT_W    = 16
) (
    input  logic               clk,
    input  logic               reset,
    pipe_hazard_unit_if.slave  hif
);

    localparam haz_entry_t BUBBLE = '0;

    haz_entry_t       ex_q;
    haz_entry_t       mem_q;
    haz_entry_t       wb_q;
    haz_entry_t       ex_d;
    logic             load_hit;
    logic             stall_c;
    logic             flush_c;
    logic             advance;
    fwd_sel_e         fwd_a_d;
    fwd_sel_e         fwd_b_d;
    fwd_sel_e         fwd_a_q;
    fwd_sel_e         fwd_b_q;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    // Youngest writer wins; a load still in EX cannot forward (that case stalls instead).
    function automatic fwd_sel_e pick_fwd(logic [REG_AW-1:0] src, logic use_src,
                                          haz_entry_t ex_e, haz_entry_t mem_e);
        if (!use_src || src == ZERO_REG) begin
            return FWD_RF;
        end
        if (entry_writing(ex_e, ZERO_REG) && !ex_e.memread && ex_e.rd == src) begin
            return FWD_EXMEM;
        end
        if (entry_writing(mem_e, ZERO_REG) && mem_e.rd == src) begin
            return FWD_MEMWB;
        end
        return FWD_RF;
    endfunction

    always_comb begin
        load_hit = entry_writing(ex_q, ZERO_REG) && ex_q.memread &&
                   ((hif.id_use_rn && hif.id_rn == ex_q.rd) ||
                    (hif.id_use_rm && hif.id_rm == ex_q.rd));
        flush_c  = hif.ex_br_taken;
        stall_c  = hif.id_valid && load_hit && !flush_c;
        advance  = hif.id_valid && !stall_c && !flush_c;

        ex_d = BUBBLE;
        if (advance) begin
            ex_d = '{valid: 1'b1, rd: hif.id_rd,
                     regwrite: hif.id_regwrite, memread: hif.id_memread};
        end

        // While stalled, look ahead one shift: the load moves to MEM, a bubble fills EX.
        fwd_a_d = FWD_RF;
        fwd_b_d = FWD_RF;
        if (stall_c) begin
            fwd_a_d = pick_fwd(hif.id_rn, hif.id_use_rn, BUBBLE, ex_q);
            fwd_b_d = pick_fwd(hif.id_rm, hif.id_use_rm, BUBBLE, ex_q);
        end else if (advance) begin
            fwd_a_d = pick_fwd(hif.id_rn, hif.id_use_rn, ex_q, mem_q);
            fwd_b_d = pick_fwd(hif.id_rm, hif.id_use_rm, ex_q, mem_q);
        end
    end

    hazard_track_reg u_ex_q (
        .clk   (clk),
        .reset (reset),
        .d     (ex_d),
        .q     (ex_q)
    );

    hazard_track_reg u_mem_q (
        .clk   (clk),
        .reset (reset),
        .d     (ex_q),
        .q     (mem_q)
    );

    hazard_track_reg u_wb_q (
        .clk   (clk),
        .reset (reset),
        .d     (mem_q),
        .q     (wb_q)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fwd_a_q     <= FWD_RF;
            fwd_b_q     <= FWD_RF;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
            if (stall_c && stall_cnt_q != '1) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (flush_c && flush_cnt_q != '1) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end

    assign hif.stall     = stall_c;
    assign hif.flush     = flush_c;
    assign hif.fwd_a     = fwd_a_q;
    assign hif.fwd_b     = fwd_b_q;
    assign hif.stall_cnt = stall_cnt_q;
    assign hif.flush_cnt = flush_cnt_q;
    assign hif.ex_ent    = ex_q;
    assign hif.mem_ent   = mem_q;
    assign hif.wb_ent    = wb_q;

endmodule
